// File: rtl/slice_pipe_adder_pkg.sv
// Shared definitions for the sliced, pipelined adder/subtractor.
package slice_pipe_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int calc_stages(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit carry-lookahead adder; also exposes the carry
// into the top bit so the caller can derive signed overflow.
module adder_slice
    import slice_pipe_adder_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE-1:0] g_s;
    logic [SLICE-1:0] p_s;
    logic [SLICE:0]   c_s;

    // Flattened lookahead: every carry is a sum of generate terms gated by
    // the propagate run above them, so no carry waits on its neighbour.
    always_comb begin
        logic pp_s;
        g_s    = a & b;
        p_s    = a ^ b;
        c_s    = '0;
        c_s[0] = ci;
        pp_s   = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            c_s[i+1] = g_s[i];
            pp_s     = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_s[i+1] = c_s[i+1] | (pp_s & g_s[j]);
                pp_s     = pp_s & p_s[j];
            end
            c_s[i+1] = c_s[i+1] | (pp_s & ci);
        end
    end

    // Sum bits and carry taps
    always_comb begin
        s     = p_s ^ c_s[SLICE-1:0];
        co    = c_s[SLICE];
        c_msb = c_s[SLICE-1];
    end

endmodule

// File: rtl/slice_pipe_adder.sv
// Pipelined multi-slice adder/subtractor: one SLICE-bit slice per stage,
// operand skew and result deskew ride beside the carry chain.
module slice_pipe_adder
    import slice_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_1,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV
);

    localparam int STAGES = calc_stages(WIDTH, SLICE);

    if (SLICE < 1) begin : g_bad_slice
        $error("slice_pipe_adder: SLICE must be at least 1");
    end else if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_width
        $error("slice_pipe_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    // Per-stage registers; slices below k of a_r/b_r and above k of s_r
    // are don't-care.
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic              ov_r;

    logic              adv_s;
    logic [WIDTH-1:0]  a_src_s  [STAGES];
    logic [WIDTH-1:0]  b_src_s  [STAGES];
    logic [WIDTH-1:0]  s_src_s  [STAGES];
    logic [WIDTH-1:0]  s_next_s [STAGES];
    logic [STAGES-1:0] ci_s;
    logic [STAGES-1:0] v_src_s;
    logic [SLICE-1:0]  sum_s [STAGES];
    logic              co_s  [STAGES];
    logic              msb_s [STAGES];

    assign adv_s     = out_ready | ~valid_r[STAGES-1];
    assign in_ready  = adv_s;
    assign out_valid = valid_r[STAGES-1];
    assign S         = s_r[STAGES-1];
    assign CO        = carry_r[STAGES-1];
    assign OV        = ov_r;

    // Stage sources: stage 0 takes the fresh beat, the rest take the
    // previous stage. B is inverted once at capture, so the mode bit
    // travels implicitly inside the skewed B operand.
    always_comb begin
        a_src_s[0] = A;
        if (mode_e'(SUB) == MODE_SUB) begin
            b_src_s[0] = ~B;
        end else begin
            b_src_s[0] = B;
        end
        s_src_s[0] = '0;
        ci_s[0]    = C_1;
        v_src_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src_s[k] = a_r[k-1];
            b_src_s[k] = b_r[k-1];
            s_src_s[k] = s_r[k-1];
            ci_s[k]    = carry_r[k-1];
            v_src_s[k] = valid_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a     (a_src_s[k][k*SLICE +: SLICE]),
            .b     (b_src_s[k][k*SLICE +: SLICE]),
            .ci    (ci_s[k]),
            .s     (sum_s[k]),
            .co    (co_s[k]),
            .c_msb (msb_s[k])
        );
    end

    // Merge each stage's new sum slice into the deskew word
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next_s[k]                    = s_src_s[k];
            s_next_s[k][k*SLICE +: SLICE]  = sum_s[k];
        end
    end

    // Pipeline, skew and valid registers; everything advances or holds together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
            valid_r <= '0;
            carry_r <= '0;
            ov_r    <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]     <= a_src_s[k];
                b_r[k]     <= b_src_s[k];
                s_r[k]     <= s_next_s[k];
                carry_r[k] <= co_s[k];
                valid_r[k] <= v_src_s[k];
            end
            ov_r <= co_s[STAGES-1] ^ msb_s[STAGES-1];
        end
    end

endmodule

// File: tb/tb_slice_pipe_adder.sv
// Self-checking bench: directed cases and random streams on 16/4, plus
// random streams on 4/4 and 32/8, against an arithmetic reference model.
module tb_slice_pipe_adder;

    logic        clk;
    logic        rst_n, rst_sw_n;
    int          n_checks, n_pass;
    logic        done4, done32;

    // 16/4 instance
    logic        in_valid, in_ready, out_valid, out_ready, c_1, sub, co, ov;
    logic [15:0] a, b, s;
    // 4/4 instance
    logic        v4_in, r4_in, v4_out, r4_out, c4, sub4, co4, ov4;
    logic [3:0]  a4, b4, s4;
    // 32/8 instance
    logic        v32_in, r32_in, v32_out, r32_out, c32, sub32, co32, ov32;
    logic [31:0] a32, b32, s32;

    logic [65:0] q16[$];
    logic [65:0] q4[$];
    logic [65:0] q32[$];

    slice_pipe_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C_1(c_1), .SUB(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .CO(co), .OV(ov));

    slice_pipe_adder #(.WIDTH(4), .SLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_sw_n), .in_valid(v4_in), .in_ready(r4_in),
        .A(a4), .B(b4), .C_1(c4), .SUB(sub4), .out_valid(v4_out),
        .out_ready(r4_out), .S(s4), .CO(co4), .OV(ov4));

    slice_pipe_adder #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst_n(rst_sw_n), .in_valid(v32_in), .in_ready(r32_in),
        .A(a32), .B(b32), .C_1(c32), .SUB(sub32), .out_valid(v32_out),
        .out_ready(r32_out), .S(s32), .CO(co32), .OV(ov32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_sw_n = 1'b0;
        #23 rst_sw_n = 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: {ov, co, s} from plain integer arithmetic on w-bit operands
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] ra,
                                              input logic [63:0] rb, input logic rc,
                                              input logic rsub);
        logic [63:0] mask, bo, am;
        logic [64:0] full;
        longint sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        am   = ra & mask;
        bo   = (rsub ? ~rb : rb) & mask;
        full = {1'b0, am} + {1'b0, bo} + {64'd0, rc};
        sa   = $signed(am << (64 - w)) >>> (64 - w);
        sb   = $signed(bo << (64 - w)) >>> (64 - w);
        sr   = sa + sb + longint'(rc);
        lim  = longint'(64'd1 << (w - 1));
        return {(sr >= lim) || (sr < -lim), full[w], full[63:0] & mask};
    endfunction

    task automatic run_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic tsub, input logic [15:0] es,
                            input logic eco, input logic eov);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; c_1 = tc; sub = tsub; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, lat, 4);
        check_val({tag, "_s"}, s, es);
        check_val({tag, "_co"}, co, eco);
        check_val({tag, "_ov"}, ov, eov);
    endtask

    // Streams n beats; rnd=0 gives A=i, B=3i with a stall on cycles 5..7
    task automatic run_stream(input int n, input bit rnd);
        int sent, got;
        logic [65:0] e;
        sent = 0; got = 0;
        q16.delete();
        for (int c = 0; c < n * 8 + 40 && got < n; c++) begin
            @(negedge clk);
            if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                if (rnd) begin
                    a = 16'($urandom); b = 16'($urandom);
                    c_1 = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                end else begin
                    a = 16'(sent); b = 16'(3 * sent); c_1 = 1'b0; sub = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(c >= 5 && c <= 7);
            #1;
            if (!rnd && !out_ready) begin
                check_val("stall_in_ready", in_ready, 0);
                check_val("stall_out_valid", out_valid, 1);
                if (q16.size() > 0) check_val("stall_hold_s", s, q16[0][63:0]);
            end
            if (in_valid && in_ready) begin
                q16.push_back(ref_model(16, {48'd0, a}, {48'd0, b}, c_1, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q16.size() == 0) begin
                    check_val("w16_unexpected_out", 1, 0);
                end else begin
                    e = q16.pop_front();
                    check_val("w16_s", s, e[63:0]);
                    check_val("w16_co", co, e[64]);
                    check_val("w16_ov", ov, e[65]);
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("w16_stream_count", got, n);
    endtask

    initial begin : sweep4
        logic [65:0] e;
        int sent, got;
        sent = 0; got = 0; done4 = 1'b0;
        v4_in = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; sub4 = 1'b0; r4_out = 1'b0;
        wait (rst_sw_n === 1'b1);
        for (int c = 0; c < 1500 && got < 150; c++) begin
            @(negedge clk);
            v4_in  = (sent < 150) && ($urandom_range(0, 3) != 0);
            a4     = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            c4     = 1'($urandom_range(0, 1)); sub4 = 1'($urandom_range(0, 1));
            r4_out = ($urandom_range(0, 2) != 0);
            #1;
            if (v4_in && r4_in) begin
                q4.push_back(ref_model(4, {60'd0, a4}, {60'd0, b4}, c4, sub4));
                sent++;
            end
            if (v4_out && r4_out) begin
                if (q4.size() == 0) begin
                    check_val("w4_unexpected_out", 1, 0);
                end else begin
                    e = q4.pop_front();
                    check_val("w4_s", s4, e[63:0]);
                    check_val("w4_co", co4, e[64]);
                    check_val("w4_ov", ov4, e[65]);
                end
                got++;
            end
        end
        check_val("w4_count", got, 150);
        done4 = 1'b1;
    end

    initial begin : sweep32
        logic [65:0] e;
        int sent, got;
        sent = 0; got = 0; done32 = 1'b0;
        v32_in = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; sub32 = 1'b0; r32_out = 1'b0;
        wait (rst_sw_n === 1'b1);
        for (int c = 0; c < 1500 && got < 150; c++) begin
            @(negedge clk);
            v32_in  = (sent < 150) && ($urandom_range(0, 3) != 0);
            a32     = $urandom; b32 = $urandom;
            c32     = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            r32_out = ($urandom_range(0, 2) != 0);
            #1;
            if (v32_in && r32_in) begin
                q32.push_back(ref_model(32, {32'd0, a32}, {32'd0, b32}, c32, sub32));
                sent++;
            end
            if (v32_out && r32_out) begin
                if (q32.size() == 0) begin
                    check_val("w32_unexpected_out", 1, 0);
                end else begin
                    e = q32.pop_front();
                    check_val("w32_s", s32, e[63:0]);
                    check_val("w32_co", co32, e[64]);
                    check_val("w32_ov", ov32, e[65]);
                end
                got++;
            end
        end
        check_val("w32_count", got, 150);
        done32 = 1'b1;
    end

    initial begin : main
        int extra;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_1 = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_s", s, 0);
        check_val("rst_co", co, 0);
        check_val("rst_ov", ov, 0);
        check_val("rst_in_ready", in_ready, 1);

        run_beat("add_carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_beat("sub_overflow",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_beat("sub_borrow",      16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        run_stream(8, 1'b0);
        run_stream(120, 1'b1);

        // Fill the pipe with the output stalled, then reset mid-flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(i + 1); b = 16'(i + 7); c_1 = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_val("pre_reset_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset_out_valid", out_valid, 0);
        check_val("midreset_s", s, 0);
        check_val("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_beat("post_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_val("post_reset_no_extra", extra, 0);

        for (int i = 0; i < 3000 && !(done4 && done32); i++) @(negedge clk);
        check_val("sweep_done", done4 && done32, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
